// File: rtl/unidade_votacao_pkg.sv
// -----------------------------------------------------------------------------
// unidade_votacao_pkg
// Shared definitions for the day-phase vote controller:
//   - default player-slot count and index width
//   - FSM state codes (also visible on the db_estado debug port)
//   - debug code reported for an unrecognised state
// No ports (package).
// -----------------------------------------------------------------------------
package unidade_votacao_pkg;

    localparam int N_JOG_PADRAO = 8;
    localparam int IDX_W_PADRAO = 3;

    localparam logic [4:0] DB_ERRO = 5'b11111;

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        ZERA        = 3'd1,
        BUSCA       = 3'd2,
        ESPERA_VOTO = 3'd3,
        REGISTRA    = 3'd4,
        PROXIMO     = 3'd5,
        APURA       = 3'd6,
        RESULTADO   = 3'd7
    } estado_t;

    // Debug code for a state: the state value zero-extended to 5 bits.
    function automatic logic [4:0] codigo_db(input estado_t e);
        return {2'b00, e};
    endfunction

endpackage

// File: rtl/unidade_votacao_apurador_max.sv
// -----------------------------------------------------------------------------
// apurador_max
// Per-target tally array plus the running max / argmax / tie scanner.
//   clock          in  rising-edge clock
//   reset          in  asynchronous, active-high
//   i_limpa        in  clear all tallies and scanner state
//   i_incrementa   in  add one (saturating) to tally[i_alvo]
//   i_alvo         in  target index for the increment
//   i_passo        in  fold tally[scan index] into max/argmax/tie, advance index
//   o_ultimo       out scan index is at the last player slot
//   o_max_prox     out running max including the current scan index
//   o_argmax_prox  out running argmax including the current scan index
//   o_empate_prox  out running tie flag including the current scan index
// The *_prox outputs let the parent latch the final result on the same edge
// that folds in the last index.
// -----------------------------------------------------------------------------
module apurador_max
    import unidade_votacao_pkg::*;
#(
    parameter int N_JOG = N_JOG_PADRAO,
    parameter int IDX_W = IDX_W_PADRAO
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_limpa,
    input  logic             i_incrementa,
    input  logic [IDX_W-1:0] i_alvo,
    input  logic             i_passo,
    output logic             o_ultimo,
    output logic [IDX_W:0]   o_max_prox,
    output logic [IDX_W-1:0] o_argmax_prox,
    output logic             o_empate_prox
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_votos [N_JOG];
    logic [IDX_W-1:0] r_indice;
    logic [IDX_W-1:0] r_argmax;
    logic [CNT_W-1:0] r_max;
    logic             r_empate;
    logic [CNT_W-1:0] w_lido;

    // Read port: tally at the current scan index (0 for indices past the array).
    always_comb begin
        w_lido = {CNT_W{1'b0}};
        for (int i = 0; i < N_JOG; i++) begin
            if (r_indice == IDX_W'(i)) begin
                w_lido = r_votos[i];
            end else begin
                w_lido = w_lido;
            end
        end
    end

    // Running max update: strictly greater replaces (so the lowest index keeps
    // the lead on equal counts), equal non-zero counts mark a tie.
    always_comb begin
        o_max_prox    = r_max;
        o_argmax_prox = r_argmax;
        o_empate_prox = r_empate;
        if (w_lido > r_max) begin
            o_max_prox    = w_lido;
            o_argmax_prox = r_indice;
            o_empate_prox = 1'b0;
        end else if ((w_lido == r_max) && (r_max != {CNT_W{1'b0}})) begin
            o_empate_prox = 1'b1;
        end else begin
            o_empate_prox = r_empate;
        end
    end

    assign o_ultimo = (r_indice == IDX_W'(N_JOG - 1));

    // Tally array: clear, or saturating increment of the addressed entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_JOG; i++) begin
                r_votos[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_JOG; i++) begin
                if (i_limpa) begin
                    r_votos[i] <= {CNT_W{1'b0}};
                end else if (i_incrementa && (i_alvo == IDX_W'(i)) && (r_votos[i] != CNT_SAT)) begin
                    r_votos[i] <= r_votos[i] + CNT_W'(1);
                end else begin
                    r_votos[i] <= r_votos[i];
                end
            end
        end
    end

    // Scanner registers: scan index and running max/argmax/tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_indice <= {IDX_W{1'b0}};
            r_argmax <= {IDX_W{1'b0}};
            r_max    <= {CNT_W{1'b0}};
            r_empate <= 1'b0;
        end else if (i_limpa) begin
            r_indice <= {IDX_W{1'b0}};
            r_argmax <= {IDX_W{1'b0}};
            r_max    <= {CNT_W{1'b0}};
            r_empate <= 1'b0;
        end else if (i_passo) begin
            r_indice <= r_indice + IDX_W'(1);
            r_argmax <= o_argmax_prox;
            r_max    <= o_max_prox;
            r_empate <= o_empate_prox;
        end else begin
            r_indice <= r_indice;
            r_argmax <= r_argmax;
            r_max    <= r_max;
            r_empate <= r_empate;
        end
    end

endmodule

// File: rtl/unidade_votacao.sv
// -----------------------------------------------------------------------------
// unidade_votacao
// Day-phase vote controller: polls living players in index order, takes one
// checked vote each, tallies per target, then scans for a unique maximum.
//   clock            in  rising-edge clock
//   reset            in  asynchronous, active-high
//   i_inicia         in  level, starts a round from OCIOSO or RESULTADO
//   i_passa          in  one-cycle confirm pulse (only used in ESPERA_VOTO)
//   i_voto           in  target index presented with i_passa
//   i_abstem         in  abstain flag presented with i_passa
//   i_vivos          in  alive mask, stable during a round
//   o_jogador_atual  out voter being polled
//   o_voto_invalido  out one-cycle pulse after a rejected i_passa
//   o_fim            out high in RESULTADO
//   o_valido         out unique non-zero maximum found
//   o_empate         out two or more targets share the non-zero maximum
//   o_eliminado      out winning target when o_valido, else 0
//   o_db_estado      out state code, DB_ERRO for an unrecognised state
// Build option: define VOTO_NULO_EN to accept i_passa with i_abstem=1 as an
// abstention (no tally change, any i_voto). Undefined, i_abstem is ignored.
// -----------------------------------------------------------------------------
module unidade_votacao
    import unidade_votacao_pkg::*;
#(
    parameter int N_JOG = N_JOG_PADRAO,
    parameter int IDX_W = IDX_W_PADRAO
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_inicia,
    input  logic             i_passa,
    input  logic [IDX_W-1:0] i_voto,
    input  logic             i_abstem,
    input  logic [N_JOG-1:0] i_vivos,
    output logic [IDX_W-1:0] o_jogador_atual,
    output logic             o_voto_invalido,
    output logic             o_fim,
    output logic             o_valido,
    output logic             o_empate,
    output logic [IDX_W-1:0] o_eliminado,
    output logic [4:0]       o_db_estado
);

    localparam int CNT_W = IDX_W + 1;
    localparam int VIV_W = 1 << IDX_W;

    estado_t          r_estado;
    estado_t          w_prox;
    logic [IDX_W-1:0] r_jogador;
    logic [IDX_W-1:0] r_voto;
    logic [IDX_W-1:0] r_eliminado;
    logic             r_voto_invalido;
    logic             r_fim;
    logic             r_valido;
    logic             r_empate;

    // Alive mask widened to every encodable index so out-of-range votes read 0.
    logic [VIV_W-1:0] w_vivos_ext;
    logic             w_jogador_vivo;
    logic             w_jogador_ultimo;
    logic             w_no_alcance;
    logic             w_alvo_vivo;
    logic             w_voto_ok;
    logic             w_abstencao;

    logic             w_limpa;
    logic             w_incrementa;
    logic             w_passo;
    logic             w_avanca;
    logic             w_captura;
    logic             w_invalido;
    logic             w_fecha;

    logic             w_scan_ultimo;
    logic [CNT_W-1:0] w_max_prox;
    logic [IDX_W-1:0] w_argmax_prox;
    logic             w_empate_prox;
    logic             w_resultado_valido;

    assign w_vivos_ext      = VIV_W'(i_vivos);
    assign w_jogador_vivo   = w_vivos_ext[r_jogador];
    assign w_jogador_ultimo = (r_jogador == IDX_W'(N_JOG - 1));
    assign w_no_alcance     = ({1'b0, i_voto} < CNT_W'(N_JOG));
    assign w_alvo_vivo      = w_vivos_ext[i_voto];
    assign w_voto_ok        = w_no_alcance && w_alvo_vivo && (i_voto != r_jogador);

`ifdef VOTO_NULO_EN
    assign w_abstencao = i_abstem;
`else
    logic w_abstem_unused;
    assign w_abstem_unused = i_abstem;
    assign w_abstencao     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox;
        end
    end

    // Next-state logic.
    always_comb begin
        w_prox = OCIOSO;
        case (r_estado)
            OCIOSO: begin
                if (i_inicia) w_prox = ZERA;
                else          w_prox = OCIOSO;
            end
            ZERA: w_prox = BUSCA;
            BUSCA: begin
                if (w_jogador_vivo)        w_prox = ESPERA_VOTO;
                else if (w_jogador_ultimo) w_prox = APURA;
                else                       w_prox = BUSCA;
            end
            ESPERA_VOTO: begin
                if (i_passa && w_abstencao)    w_prox = PROXIMO;
                else if (i_passa && w_voto_ok) w_prox = REGISTRA;
                else                           w_prox = ESPERA_VOTO;
            end
            REGISTRA: w_prox = PROXIMO;
            PROXIMO: begin
                if (w_jogador_ultimo) w_prox = APURA;
                else                  w_prox = BUSCA;
            end
            APURA: begin
                if (w_scan_ultimo) w_prox = RESULTADO;
                else               w_prox = APURA;
            end
            RESULTADO: begin
                if (i_inicia) w_prox = ZERA;
                else          w_prox = RESULTADO;
            end
            default: w_prox = OCIOSO;
        endcase
    end

    // Output/control decode: datapath strobes for the current state.
    always_comb begin
        w_limpa      = 1'b0;
        w_incrementa = 1'b0;
        w_passo      = 1'b0;
        w_avanca     = 1'b0;
        w_captura    = 1'b0;
        w_invalido   = 1'b0;
        w_fecha      = 1'b0;
        case (r_estado)
            ZERA:        w_limpa = 1'b1;
            BUSCA:       w_avanca = !w_jogador_vivo && !w_jogador_ultimo;
            ESPERA_VOTO: begin
                w_captura  = i_passa && !w_abstencao && w_voto_ok;
                w_invalido = i_passa && !w_abstencao && !w_voto_ok;
            end
            REGISTRA:    w_incrementa = 1'b1;
            PROXIMO:     w_avanca = !w_jogador_ultimo;
            APURA: begin
                w_passo = 1'b1;
                w_fecha = w_scan_ultimo;
            end
            default:     w_limpa = 1'b0;
        endcase
    end

    assign w_resultado_valido = (w_max_prox != {CNT_W{1'b0}}) && !w_empate_prox;

    // Datapath registers: voter counter, captured vote and registered outputs.
    // Results are cleared on the edge entering ZERA so they drop together with fim.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_jogador       <= {IDX_W{1'b0}};
            r_voto          <= {IDX_W{1'b0}};
            r_voto_invalido <= 1'b0;
            r_fim           <= 1'b0;
            r_valido        <= 1'b0;
            r_empate        <= 1'b0;
            r_eliminado     <= {IDX_W{1'b0}};
        end else begin
            if (w_limpa) begin
                r_jogador <= {IDX_W{1'b0}};
            end else if (w_avanca) begin
                r_jogador <= r_jogador + IDX_W'(1);
            end else begin
                r_jogador <= r_jogador;
            end

            if (w_captura) begin
                r_voto <= i_voto;
            end else begin
                r_voto <= r_voto;
            end

            r_voto_invalido <= w_invalido;
            r_fim           <= (w_prox == RESULTADO);

            if (w_prox == ZERA) begin
                r_valido    <= 1'b0;
                r_empate    <= 1'b0;
                r_eliminado <= {IDX_W{1'b0}};
            end else if (w_fecha) begin
                r_valido    <= w_resultado_valido;
                r_empate    <= w_empate_prox;
                r_eliminado <= w_resultado_valido ? w_argmax_prox : {IDX_W{1'b0}};
            end else begin
                r_valido    <= r_valido;
                r_empate    <= r_empate;
                r_eliminado <= r_eliminado;
            end
        end
    end

    // Debug state code.
    always_comb begin
        case (r_estado)
            OCIOSO, ZERA, BUSCA, ESPERA_VOTO,
            REGISTRA, PROXIMO, APURA, RESULTADO: o_db_estado = codigo_db(r_estado);
            default:                             o_db_estado = DB_ERRO;
        endcase
    end

    apurador_max #(
        .N_JOG (N_JOG),
        .IDX_W (IDX_W)
    ) u_apurador (
        .clock         (clock),
        .reset         (reset),
        .i_limpa       (w_limpa),
        .i_incrementa  (w_incrementa),
        .i_alvo        (r_voto),
        .i_passo       (w_passo),
        .o_ultimo      (w_scan_ultimo),
        .o_max_prox    (w_max_prox),
        .o_argmax_prox (w_argmax_prox),
        .o_empate_prox (w_empate_prox)
    );

    assign o_jogador_atual = r_jogador;
    assign o_voto_invalido = r_voto_invalido;
    assign o_fim           = r_fim;
    assign o_valido        = r_valido;
    assign o_empate        = r_empate;
    assign o_eliminado     = r_eliminado;

endmodule

// File: tb/tb_unidade_votacao.sv
// -----------------------------------------------------------------------------
// tb_unidade_votacao
// Self-checking bench: a table of hand-derived rounds, randomised rounds
// checked against a tally model, plus hand sequences for rejected votes,
// reset mid-round and a 10-slot instance.
// -----------------------------------------------------------------------------
module tb_unidade_votacao;

`ifdef VOTO_NULO_EN
    localparam bit NULO = 1'b1;
`else
    localparam bit NULO = 1'b0;
`endif

    logic       clock;
    logic       reset;

    logic       inicia, passa, abstem;
    logic [2:0] voto;
    logic [7:0] vivos;
    logic [2:0] jogador_atual, eliminado;
    logic       voto_invalido, fim, valido, empate;
    logic [4:0] db_estado;

    logic       inicia10, passa10, abstem10;
    logic [3:0] voto10;
    logic [9:0] vivos10;
    logic [3:0] jog10, elim10;
    logic       inv10, fim10, val10, emp10;
    logic [4:0] db10;

    int n_chk  = 0;
    int n_fail = 0;

    unidade_votacao #(.N_JOG(8), .IDX_W(3)) dut (
        .clock(clock), .reset(reset), .i_inicia(inicia), .i_passa(passa),
        .i_voto(voto), .i_abstem(abstem), .i_vivos(vivos),
        .o_jogador_atual(jogador_atual), .o_voto_invalido(voto_invalido),
        .o_fim(fim), .o_valido(valido), .o_empate(empate),
        .o_eliminado(eliminado), .o_db_estado(db_estado)
    );

    unidade_votacao #(.N_JOG(10), .IDX_W(4)) dut10 (
        .clock(clock), .reset(reset), .i_inicia(inicia10), .i_passa(passa10),
        .i_voto(voto10), .i_abstem(abstem10), .i_vivos(vivos10),
        .o_jogador_atual(jog10), .o_voto_invalido(inv10),
        .o_fim(fim10), .o_valido(val10), .o_empate(emp10),
        .o_eliminado(elim10), .o_db_estado(db10)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]      vivos;
        logic [7:0][2:0] votos;
        logic [7:0]      abst;
        logic            e_valido;
        logic            e_empate;
        logic [2:0]      e_elim;
    } vetor_t;

    vetor_t tab [8];

    task automatic chk(input string nome, input int atual, input int esperado);
        n_chk++;
        if (atual != esperado) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    function automatic logic [7:0][2:0] mk(input int v0, input int v1, input int v2, input int v3,
                                           input int v4, input int v5, input int v6, input int v7);
        logic [7:0][2:0] r;
        r[0] = 3'(v0); r[1] = 3'(v1); r[2] = 3'(v2); r[3] = 3'(v3);
        r[4] = 3'(v4); r[5] = 3'(v5); r[6] = 3'(v6); r[7] = 3'(v7);
        return r;
    endfunction

    // Reference: count votes per target, find the maximum and how many share it.
    task automatic modelo(input logic [7:0] viv, input logic [7:0][2:0] votos, input logic [7:0] abst,
                          output logic v, output logic e, output logic [2:0] el);
        int cont [8];
        int mx, n, arg;
        for (int i = 0; i < 8; i++) cont[i] = 0;
        for (int j = 0; j < 8; j++)
            if (viv[j] && !(NULO && abst[j])) cont[votos[j]] = cont[votos[j]] + 1;
        mx = 0;
        for (int i = 0; i < 8; i++) if (cont[i] > mx) mx = cont[i];
        n = 0; arg = 0;
        for (int i = 7; i >= 0; i--) if (cont[i] == mx) begin n++; arg = i; end
        v  = (mx > 0) && (n == 1);
        e  = (mx > 0) && (n > 1);
        el = v ? 3'(arg) : 3'd0;
    endtask

    task automatic espera_voto(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (db_estado == 5'd3) ok = 1'b1;
            else @(negedge clock);
        end
        if (!ok) chk("timeout_espera_voto", int'(db_estado), 3);
    endtask

    task automatic votar(input logic [2:0] alvo, input logic abst, input bit inv);
        voto = alvo; abstem = abst; passa = 1'b1;
        @(negedge clock);
        passa = 1'b0; abstem = 1'b0;
        chk("voto_invalido", int'(voto_invalido), int'(inv));
        if (inv) chk("estado_mantido", int'(db_estado), 3);
    endtask

    task automatic rodada(input logic [7:0] viv, input logic [7:0][2:0] votos, input logic [7:0] abst,
                          input bit tenta_inv, input logic ev, input logic ee, input logic [2:0] eel);
        bit ok;
        int ultimo, k, morto;
        vivos = viv;
        inicia = 1'b1;
        @(negedge clock);
        inicia = 1'b0;
        ultimo = -1;
        for (int j = 0; j < 8; j++) begin
            if (viv[j]) begin
                espera_voto(ok);
                if (!ok) return;
                chk("jogador_atual", int'(jogador_atual), j);
                if (tenta_inv) begin
                    votar(3'(j), 1'b0, 1'b1);
                    morto = -1;
                    for (int d = 7; d >= 0; d--) if (!viv[d]) morto = d;
                    if (morto >= 0) votar(3'(morto), 1'b0, 1'b1);
                end
                votar(votos[j], abst[j], 1'b0);
                ultimo = j;
            end
        end
        k = 1;
        while (!fim && k < 40) begin
            @(negedge clock);
            k++;
        end
        chk("fim", int'(fim), 1);
        if (ultimo == 7 && !(NULO && abst[7])) chk("latencia_fim", k, 11);
        if (ultimo < 0) chk("fim_sem_vivos_no_prazo", int'(k <= 20), 1);
        chk("db_resultado", int'(db_estado), 7);
        chk("valido", int'(valido), int'(ev));
        chk("empate", int'(empate), int'(ee));
        chk("eliminado", int'(eliminado), int'(eel));
    endtask

    task automatic votar10(input logic [3:0] alvo, input bit inv);
        voto10 = alvo; passa10 = 1'b1;
        @(negedge clock);
        passa10 = 1'b0;
        chk("dut10_voto_invalido", int'(inv10), int'(inv));
        if (inv) chk("dut10_estado_mantido", int'(db10), 3);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] viv;
        logic [7:0][2:0] vts;
        logic mv, me;
        logic [2:0] mel;
        bit ok;
        int t;

        reset = 1'b1;
        inicia = 1'b0; passa = 1'b0; abstem = 1'b0; voto = 3'd0; vivos = 8'hFF;
        inicia10 = 1'b0; passa10 = 1'b0; abstem10 = 1'b0; voto10 = 4'd0; vivos10 = 10'h0;

        tab[0] = '{8'hFF, mk(3,3,3,1,1,0,2,3), 8'h00, 1'b1, 1'b0, 3'd3};
        tab[1] = '{8'hA5, mk(2,0,5,0,0,2,0,5), 8'h00, 1'b0, 1'b1, 3'd0};
        tab[2] = '{8'h00, mk(0,0,0,0,0,0,0,0), 8'h00, 1'b0, 1'b0, 3'd0};
        tab[3] = '{8'h03, mk(1,0,0,0,0,0,0,0), 8'h00, 1'b0, 1'b1, 3'd0};
        tab[4] = '{8'h81, mk(7,0,0,0,0,0,0,0), 8'h00, 1'b0, 1'b1, 3'd0};
        tab[5] = '{8'hFF, mk(1,0,1,1,1,1,1,1), 8'h00, 1'b1, 1'b0, 3'd1};
        tab[6] = '{8'hFF, mk(1,0,1,1,1,1,1,1), 8'hFF, !NULO, 1'b0, NULO ? 3'd0 : 3'd1};
        tab[7] = '{8'hFF, mk(7,7,7,7,7,7,7,6), 8'h00, 1'b1, 1'b0, 3'd7};

        @(negedge clock);
        @(negedge clock);
        chk("reset_db", int'(db_estado), 0);
        chk("reset_fim", int'(fim), 0);
        chk("reset_valido", int'(valido), 0);
        chk("reset_empate", int'(empate), 0);
        chk("reset_eliminado", int'(eliminado), 0);
        chk("reset_jogador", int'(jogador_atual), 0);
        chk("reset_invalido", int'(voto_invalido), 0);
        reset = 1'b0;
        @(negedge clock);

        // passa outside ESPERA_VOTO does nothing
        passa = 1'b1; voto = 3'd2;
        @(negedge clock);
        passa = 1'b0;
        chk("passa_ocioso_db", int'(db_estado), 0);
        chk("passa_ocioso_inv", int'(voto_invalido), 0);

        for (int i = 0; i < 8; i++)
            rodada(tab[i].vivos, tab[i].votos, tab[i].abst, 1'b0,
                   tab[i].e_valido, tab[i].e_empate, tab[i].e_elim);

        // passa in RESULTADO is ignored and results hold
        passa = 1'b1; voto = 3'd1;
        @(negedge clock);
        passa = 1'b0;
        @(negedge clock);
        chk("resultado_hold_db", int'(db_estado), 7);
        chk("resultado_hold_fim", int'(fim), 1);
        chk("resultado_hold_elim", int'(eliminado), 7);
        chk("resultado_hold_inv", int'(voto_invalido), 0);

        // rejected votes: self vote and vote for dead player 4, then accepted votes
        viv = 8'b1110_1111;
        vts = mk(2,2,3,2,0,1,2,2);
        modelo(viv, vts, 8'h00, mv, me, mel);
        rodada(viv, vts, 8'h00, 1'b1, mv, me, mel);

        // randomised rounds against the tally model
        for (int r = 0; r < 16; r++) begin
            viv = 8'($urandom);
            if ($countones(viv) == 1) viv = viv | ((viv == 8'h01) ? 8'h02 : 8'h01);
            for (int j = 0; j < 8; j++) begin
                vts[j] = 3'd0;
                if (viv[j]) begin
                    t = $urandom_range(0, 7);
                    while (!(viv[t] && t != j)) t = $urandom_range(0, 7);
                    vts[j] = 3'(t);
                end
            end
            modelo(viv, vts, 8'h00, mv, me, mel);
            rodada(viv, vts, 8'h00, bit'($urandom_range(0, 1)), mv, me, mel);
        end

        // reset during ESPERA_VOTO after three votes
        vivos = 8'hFF;
        inicia = 1'b1;
        @(negedge clock);
        inicia = 1'b0;
        for (int j = 0; j < 3; j++) begin
            espera_voto(ok);
            votar(3'd6, 1'b0, 1'b0);
        end
        espera_voto(ok);
        chk("pre_reset_jogador", int'(jogador_atual), 3);
        reset = 1'b1;
        #1;
        chk("reset_meio_db", int'(db_estado), 0);
        chk("reset_meio_fim", int'(fim), 0);
        chk("reset_meio_jogador", int'(jogador_atual), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        rodada(8'b0100_0011, mk(6,6,0,0,0,0,0,0), 8'h00, 1'b0, 1'b1, 1'b0, 3'd6);

        // 10-slot instance: out-of-range, dead and self votes are rejected
        vivos10 = 10'h1FF;
        inicia10 = 1'b1;
        @(negedge clock);
        inicia10 = 1'b0;
        for (int j = 0; j < 9; j++) begin
            ok = 1'b0;
            for (int k = 0; k < 40 && !ok; k++) begin
                if (db10 == 5'd3) ok = 1'b1;
                else @(negedge clock);
            end
            chk("dut10_espera", int'(ok), 1);
            chk("dut10_jogador", int'(jog10), j);
            if (j == 0) begin
                votar10(4'd9, 1'b1);
                votar10(4'd12, 1'b1);
                votar10(4'd0, 1'b1);
            end
            votar10((j == 1) ? 4'd0 : 4'd1, 1'b0);
        end
        for (int k = 0; k < 40 && !fim10; k++) @(negedge clock);
        chk("dut10_fim", int'(fim10), 1);
        chk("dut10_valido", int'(val10), 1);
        chk("dut10_empate", int'(emp10), 0);
        chk("dut10_eliminado", int'(elim10), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
